me_full_search: RTL and testbench

ME_FULL_SEARCH -- requirements
Module: me_full_search

---
 rtl/me_full_search_if.sv | 36 +++
 rtl/me_full_search.sv | 136 +++++++++++++
 tb/tb_me_full_search.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/me_full_search_if.sv
// rtl/me_full_search_if.sv - request, pixel-fetch and result signals of the full-search motion estimator
// master: estimator side; slave: pixel memories and result consumer.
interface me_full_search_if #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48,
  parameter int PIX_W      = 8
);
  localparam int P     = SEARCH_DIM - MACRO_DIM + 1;
  localparam int SAD_W = $clog2(MACRO_DIM * MACRO_DIM * (2**PIX_W - 1) + 1);
  localparam int MV_W  = $clog2(P) + 1;
  localparam int RW    = $clog2(MACRO_DIM);
  localparam int AW    = $clog2(SEARCH_DIM);

  logic                              start;
  logic                              ready;
  logic [RW-1:0]                     cur_row;
  logic [AW-1:0]                     srch_row;
  logic [AW-1:0]                     srch_col;
  logic [MACRO_DIM-1:0][PIX_W-1:0]   pixel_cpr_in;
  logic [MACRO_DIM-1:0][PIX_W-1:0]   pixel_spr_in;
  logic                              out_valid;
  logic                              out_ready;
  logic [SAD_W-1:0]                  min_sad;
  logic signed [MV_W-1:0]            mv_x;
  logic signed [MV_W-1:0]            mv_y;

  modport master (
    input  start, pixel_cpr_in, pixel_spr_in, out_ready,
    output ready, cur_row, srch_row, srch_col, out_valid, min_sad, mv_x, mv_y
  );

  modport slave (
    output start, pixel_cpr_in, pixel_spr_in, out_ready,
    input  ready, cur_row, srch_row, srch_col, out_valid, min_sad, mv_x, mv_y
  );
endinterface

// File: rtl/me_full_search.sv
// rtl/me_full_search.sv - full-search block-matching motion estimator, one SAD row per cycle
// Optional ME_EARLY_TERM_EN: abandon a candidate as soon as its partial SAD reaches the best so far.
module me_full_search #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48,
  parameter int PIX_W      = 8
) (
  input logic               clk,
  input logic               rst_n,
  me_full_search_if.master  bus
);
  localparam int P     = SEARCH_DIM - MACRO_DIM + 1;
  localparam int C     = (P - 1) / 2;
  localparam int SAD_W = $clog2(MACRO_DIM * MACRO_DIM * (2**PIX_W - 1) + 1);
  localparam int MV_W  = $clog2(P) + 1;
  localparam int RW    = $clog2(MACRO_DIM);
  localparam int AW    = $clog2(SEARCH_DIM);
  localparam int CW    = $clog2(P);

  typedef enum logic [1:0] {IDLE, ACCUM, CMP, OUT} state_t;

  state_t                 state_q, state_d;
  logic [RW-1:0]          row_q, row_d;
  logic [CW-1:0]          x_q, x_d, y_q, y_d;
  logic [CW-1:0]          x_nxt, y_nxt;
  logic [SAD_W-1:0]       acc_q, acc_d, best_q, best_d;
  logic [SAD_W-1:0]       row_sad, sum_next;
  logic signed [MV_W-1:0] mv_x_q, mv_x_d, mv_y_q, mv_y_d;
  logic                   first_cand, last_cand, abandon, addr_active;

  // Larger-minus-smaller keeps the PIX_W subtraction exact before widening.
  always_comb begin
    row_sad = '0;
    for (int i = 0; i < MACRO_DIM; i++) begin
      row_sad = row_sad + SAD_W'((bus.pixel_cpr_in[i] > bus.pixel_spr_in[i]) ?
                                 (bus.pixel_cpr_in[i] - bus.pixel_spr_in[i]) :
                                 (bus.pixel_spr_in[i] - bus.pixel_cpr_in[i]));
    end
  end

  assign sum_next   = acc_q + row_sad;
  assign first_cand = (x_q == '0) && (y_q == '0);
  assign last_cand  = (x_q == CW'(P - 1)) && (y_q == CW'(P - 1));
  assign x_nxt      = (x_q == CW'(P - 1)) ? '0 : x_q + 1'b1;
  assign y_nxt      = (x_q == CW'(P - 1)) ? y_q + 1'b1 : y_q;

`ifdef ME_EARLY_TERM_EN
  assign abandon = !first_cand && (sum_next >= best_q);
`else
  assign abandon = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    best_d  = best_q;
    mv_x_d  = mv_x_q;
    mv_y_d  = mv_y_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACCUM;
          row_d   = '0;
          x_d     = '0;
          y_d     = '0;
          acc_d   = '0;
        end
      end
      ACCUM: begin
        if (abandon) begin
          acc_d = '0;
          row_d = '0;
          x_d   = x_nxt;
          y_d   = y_nxt;
          if (last_cand) state_d = OUT;
        end else begin
          acc_d = sum_next;
          if (row_q == RW'(MACRO_DIM - 1)) state_d = CMP;
          else                             row_d   = row_q + 1'b1;
        end
      end
      CMP: begin
        // Strict compare: the earliest raster candidate keeps a tie.
        if (first_cand || (acc_q < best_q)) begin
          best_d = acc_q;
          mv_x_d = MV_W'(x_q) - MV_W'(C);
          mv_y_d = MV_W'(y_q) - MV_W'(C);
        end
        acc_d   = '0;
        row_d   = '0;
        x_d     = x_nxt;
        y_d     = y_nxt;
        state_d = last_cand ? OUT : ACCUM;
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      best_q  <= '0;
      mv_x_q  <= '0;
      mv_y_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      best_q  <= best_d;
      mv_x_q  <= mv_x_d;
      mv_y_q  <= mv_y_d;
    end
  end

  assign addr_active   = (state_q == ACCUM) || (state_q == CMP);
  assign bus.ready     = (state_q == IDLE);
  assign bus.out_valid = (state_q == OUT);
  assign bus.min_sad   = best_q;
  assign bus.mv_x      = mv_x_q;
  assign bus.mv_y      = mv_y_q;
  assign bus.cur_row   = addr_active ? row_q : '0;
  assign bus.srch_row  = addr_active ? (AW'(y_q) + AW'(row_q)) : '0;
  assign bus.srch_col  = addr_active ? AW'(x_q) : '0;
endmodule

// File: tb/tb_me_full_search.sv
// tb/tb_me_full_search.sv - directed scoreboard bench for me_full_search (4x4 in 8x8, plus one default-size run)
module tb_me_full_search;
  localparam int MD = 4;
  localparam int SD = 8;
  localparam int PW = 8;
  localparam int LAT_SMALL = 125;
  localparam int LAT_BIG   = 18513;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  me_full_search_if #(.MACRO_DIM(MD), .SEARCH_DIM(SD), .PIX_W(PW)) sif ();
  me_full_search #(.MACRO_DIM(MD), .SEARCH_DIM(SD), .PIX_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(sif));

  me_full_search_if dif ();
  me_full_search dut_big (.clk(clk), .rst_n(rst_n), .bus(dif));
  assign dif.pixel_cpr_in = '1;
  assign dif.pixel_spr_in = '0;

  logic [7:0] cur_mem  [0:MD-1][0:MD-1];
  logic [7:0] srch_mem [0:SD-1][0:SD-1];

  always_comb begin
    for (int i = 0; i < MD; i++) begin
      sif.pixel_cpr_in[i] = cur_mem[sif.cur_row][i];
      sif.pixel_spr_in[i] = srch_mem[sif.srch_row][(int'(sif.srch_col) + i) % SD];
    end
  end

  typedef struct { int sad; int mvx; int mvy; int lat; } exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic load_const(input logic [7:0] cv, input logic [7:0] sv);
    for (int r = 0; r < MD; r++) for (int c = 0; c < MD; c++) cur_mem[r][c] = cv;
    for (int r = 0; r < SD; r++) for (int c = 0; c < SD; c++) srch_mem[r][c] = sv;
  endtask

  task automatic load_copy();
    load_const(8'h00, 8'hFF);
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++) begin
        cur_mem[r][c]      = 8'(r * MD + c + 1);
        srch_mem[1 + r][2 + c] = 8'(r * MD + c + 1);
      end
  endtask

  task automatic check_result(input string tag, input exp_t e);
    check({tag, "_sad"}, sif.min_sad, e.sad);
    check({tag, "_mvx"}, sif.mv_x, e.mvx);
    check({tag, "_mvy"}, sif.mv_y, e.mvy);
  endtask

  task automatic do_search(input string tag, input exp_t e, input bit accept);
    int cyc;
    exp_t got;
    sb.push_back(e);
    sif.start = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
    cyc = 0;
    while (!sif.out_valid && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_valid"}, sif.out_valid, 1);
    got = sb.pop_front();
`ifdef ME_EARLY_TERM_EN
    check({tag, "_lat_early"}, (cyc < got.lat) ? 1 : 0, 1);
`else
    check({tag, "_lat"}, cyc, got.lat);
`endif
    check_result(tag, got);
    if (accept) begin
      sif.out_ready = 1'b1;
      @(posedge clk); #1;
      sif.out_ready = 1'b0;
      check({tag, "_ready_after"}, sif.ready, 1);
    end
  endtask

  exp_t e_copy, e_zero, e_max;
  int   cyc_big;

  initial begin
    e_copy = '{sad: 0,    mvx: 0,  mvy: -1, lat: LAT_SMALL};
    e_zero = '{sad: 0,    mvx: -2, mvy: -2, lat: LAT_SMALL};
    e_max  = '{sad: 4080, mvx: -2, mvy: -2, lat: LAT_SMALL};
    sif.start = 1'b0; sif.out_ready = 1'b0;
    dif.start = 1'b0; dif.out_ready = 1'b0;
    load_copy();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", sif.ready, 1);
    check("rst_valid", sif.out_valid, 0);
    check("rst_sad", sif.min_sad, 0);
    check("rst_mvx", sif.mv_x, 0);
    check("rst_srow", sif.srch_row, 0);
    rst_n = 1'b1;

    do_search("copy", e_copy, 1'b1);
    load_const(8'h00, 8'h00);
    do_search("zero", e_zero, 1'b1);
    load_const(8'hFF, 8'h00);
    do_search("max", e_max, 1'b1);

    // Result must hold while the consumer stalls; start pulses are ignored.
    load_copy();
    do_search("hold", e_copy, 1'b0);
    for (int k = 0; k < 10; k++) begin
      sif.start = (k == 4);
      @(posedge clk); #1;
      check_result("hold_stall", e_copy);
      check("hold_valid", sif.out_valid, 1);
      check("hold_ready", sif.ready, 0);
      check("hold_scol", sif.srch_col, 0);
      check("hold_crow", sif.cur_row, 0);
    end
    sif.start = 1'b1;
    sif.out_ready = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
    sif.out_ready = 1'b0;
    check("accept_ready", sif.ready, 1);
    repeat (3) @(posedge clk);
    #1;
    check("accept_idle", sif.ready, 1);
    check("accept_novalid", sif.out_valid, 0);

    // Asynchronous reset in the middle of candidate 7.
    sb.push_back(e_copy);
    sif.start = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
    repeat (7 * (MD + 1) + 2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_valid", sif.out_valid, 0);
    check("midrst_ready", sif.ready, 1);
    check("midrst_sad", sif.min_sad, 0);
    check("midrst_mvx", sif.mv_x, 0);
    check("midrst_mvy", sif.mv_y, 0);
    check("midrst_srow", sif.srch_row, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_search("after_rst", e_copy, 1'b1);

    // Default-size instance: all-0xFF block against an all-zero window.
    dif.start = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0;
    cyc_big = 0;
    while (!dif.out_valid && cyc_big < 20000) begin
      @(posedge clk); #1;
      cyc_big++;
    end
    check("big_valid", dif.out_valid, 1);
`ifdef ME_EARLY_TERM_EN
    check("big_lat_early", (cyc_big <= LAT_BIG) ? 1 : 0, 1);
`else
    check("big_lat", cyc_big, LAT_BIG);
`endif
    check("big_sad", dif.min_sad, 65280);
    check("big_mvx", dif.mv_x, -16);
    check("big_mvy", dif.mv_y, -16);
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    dif.out_ready = 1'b0;
    check("big_ready_after", dif.ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
